system_bus_ram: RTL and testbench
=================================

Name: system_bus_ram

Overview:
- System bus responder: the target end of the bus the CPU drives as initiator.
- Serves single-word reads and byte-masked writes from an internal word-addressed RAM.
- Returns read data with a fixed, parameterised latency; reads are fully pipelined.
- Optionally zero-fills the whole RAM after reset, holding ready low while it does so.
- Sits behind the system bus interconnect as program/data memory for the CPU.

Parameters:
ADDR_BITS, 10, word-address width; RAM depth = 2^ADDR_BITS 32-bit words
READ_LATENCY, 1, cycles from read acceptance to read_data_valid; legal range 1..4
CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset before accepting requests; 0 = no fill

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
system_bus_ready  output  1  responder can accept a request this cycle
system_bus_addr  input  32  byte address; bits [ADDR_BITS+1:2] select the word
system_bus_write_data  input  32  write data
system_bus_byte_enable  input  4  per-byte write mask; bit i enables bits [8i+7:8i]
system_bus_write_req  input  1  write request
system_bus_read_req  input  1  read request
system_bus_read_data  output  32  read data; valid only when system_bus_read_data_valid = 1
system_bus_read_data_valid  output  1  one-cycle pulse per accepted read

Behaviour:
- Reset (clk edge with reset = 1):
  - ready = 0, read_data_valid = 0, read_data = 0.
  - Read pipeline flushed; in-flight reads are dropped and never return.
  - Clear counter set to 0; state = CLEAR if CLEAR_ON_RESET = 1, else IDLE.
- Reset mid-CLEAR restarts the clear from word 0.
- States: CLEAR, IDLE.
  - CLEAR: ready = 0. Writes zero to word[counter] each cycle, then increments counter. After word 2^ADDR_BITS-1 is written, goes to IDLE; ready = 1 the next cycle. Clear takes exactly 2^ADDR_BITS cycles. Requests presented in CLEAR are ignored; no side effects.
  - IDLE: ready = 1 every cycle. There is no backpressure.
- Acceptance: a request is accepted on a clk edge where ready = 1 and the request signal = 1. Requests with ready = 0 are ignored, not queued.
- Write:
  - Bytes with byte_enable bit = 1 are updated; others are kept.
  - byte_enable = 0 produces no change.
  - Write completes in the accept cycle; there is no response.
- Read:
  - byte_enable ignored; returns the full word.
  - Accepted at edge N -> read_data_valid = 1 with data for exactly one cycle, READ_LATENCY edges later (edge N+READ_LATENCY).
  - Back-to-back reads every cycle give back-to-back valid pulses, in order.
- Ordering:
  - A read returns memory contents including every write accepted before it.
  - A write accepted after a read does not affect that read's data, including for READ_LATENCY > 1.
- Simultaneous write_req and read_req: the write is performed, the read is dropped, and no valid pulse is generated.
- Addressing:
  - addr[1:0] ignored; bits above ADDR_BITS+1 ignored.
  - Out-of-range addresses alias modulo the RAM depth.
- read_data holds its last value while valid = 0. Only read_data sampled with valid = 1 is meaningful.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_BITS=4: deassert reset -> ready low for exactly 16 cycles, then high. Read of every address 0x00..0x3C returns 0x00000000.
- Write 0xDEADBEEF to 0x10 with be=4'hF, then write 0x000000AA with be=4'b0001, then read 0x10 -> returns 0xDEADBEAA exactly READ_LATENCY cycles after acceptance.
- READ_LATENCY=3: read 0x0,0x4,0x8 on consecutive cycles after preloading 1,2,3 -> valid high on 3 consecutive cycles carrying 1,2,3. Then issue a write to 0x4 on the cycle after the reads -> the second read still returns 2.
- Read and write to the same address asserted together -> write lands; read_data_valid stays 0 for 4 cycles.
- Reset pulsed one cycle after a read is accepted (READ_LATENCY=2) -> no valid pulse appears, ready = 0 the cycle after reset, and clear restarts (CLEAR_ON_RESET=1).
- ADDR_BITS=4: write 0x12345678 to 0x44 -> read of 0x04 returns 0x12345678 (aliasing). Request held during CLEAR -> no write effect observed afterwards.

Source files
------------

// File: rtl/system_bus_ram.sv
// System bus responder: word-addressed RAM with byte-masked writes,
// fixed-latency pipelined reads and optional zero-fill after reset.
module system_bus_ram #(
    parameter int ADDR_BITS      = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        system_bus_ready,
    input  logic [31:0] system_bus_addr,
    input  logic [31:0] system_bus_write_data,
    input  logic [3:0]  system_bus_byte_enable,
    input  logic        system_bus_write_req,
    input  logic        system_bus_read_req,
    output logic [31:0] system_bus_read_data,
    output logic        system_bus_read_data_valid
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] CNT_ONE = 1;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_BITS-1:0]   r_clr_cnt;
    logic [ADDR_BITS-1:0]   w_clr_cnt_nxt;
    logic                   r_ready;
    logic                   w_ready_nxt;
    logic                   w_clr_we;

    logic [31:0]            r_mem [DEPTH];

    logic [ADDR_BITS-1:0]   w_word;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_mem_we;
    logic [ADDR_BITS-1:0]   w_mem_addr;
    logic [31:0]            w_mem_wdata;
    logic [3:0]             w_mem_be;
    logic                   w_unused_addr;

    logic [READ_LATENCY-1:0]       r_vld;
    logic [READ_LATENCY-1:0][31:0] r_dat;

    assign w_word        = system_bus_addr[ADDR_BITS+1:2];
    assign w_unused_addr = ^{system_bus_addr[31:ADDR_BITS+2],
                             system_bus_addr[1:0]};

    // A write wins over a simultaneous read; the read is dropped.
    assign w_wr_acc = r_ready & system_bus_write_req & ~reset;
    assign w_rd_acc = r_ready & system_bus_read_req
                    & ~system_bus_write_req & ~reset;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_ready_nxt   = 1'b0;
        w_clr_we      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + CNT_ONE;
                if (r_clr_cnt == '1) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end
            end
            S_IDLE: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign w_mem_we    = (w_clr_we & ~reset) | w_wr_acc;
    assign w_mem_addr  = w_clr_we ? r_clr_cnt : w_word;
    assign w_mem_wdata = w_clr_we ? 32'h0 : system_bus_write_data;
    assign w_mem_be    = w_clr_we ? 4'hF : system_bus_byte_enable;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Data is captured at acceptance so later writes cannot leak into it;
    // each stage only loads on a valid so the last stage holds its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_dat <= '0;
        end else begin
            r_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_dat[0] <= r_mem[w_word];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign system_bus_ready           = r_ready;
    assign system_bus_read_data_valid = r_vld[READ_LATENCY-1];
    assign system_bus_read_data       = r_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_system_bus_ram.sv
// Directed bench for system_bus_ram: clear, byte writes, pipelined reads,
// ordering, write/read collision, aliasing and reset mid-flight.
module tb_system_bus_ram;

    localparam int AB  = 4;
    localparam int LAT = 3;

    logic        clk;
    logic        reset;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wreq;
    logic        rreq;
    logic [31:0] rdata;
    logic        valid;

    int errors;
    int checks;

    system_bus_ram #(
        .ADDR_BITS      (AB),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1)
    ) u_dut (
        .clk                        (clk),
        .reset                      (reset),
        .system_bus_ready           (ready),
        .system_bus_addr            (addr),
        .system_bus_write_data      (wdata),
        .system_bus_byte_enable     (be),
        .system_bus_write_req       (wreq),
        .system_bus_read_req        (rreq),
        .system_bus_read_data       (rdata),
        .system_bus_read_data_valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
        addr  = a;
        wdata = d;
        be    = m;
        wreq  = 1'b1;
        tick();
        wreq  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output int lat);
        addr = a;
        rreq = 1'b1;
        tick();
        rreq = 1'b0;
        lat  = 1;
        while (!valid && lat < 10) begin
            tick();
            lat++;
        end
        d = rdata;
        if (!valid) lat = 99;
    endtask

    logic [31:0] d;
    int          lat;
    int          n;
    logic        seen;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        addr   = '0;
        wdata  = '0;
        be     = '0;
        wreq   = 1'b0;
        rreq   = 1'b0;

        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);

        // write held during the clear must be ignored
        reset = 1'b0;
        addr  = 32'h8;
        wdata = 32'hFFFF_FFFF;
        be    = 4'hF;
        wreq  = 1'b1;
        n     = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        wreq = 1'b0;
        chk("clear_cycles", 32'(n), 32'd16);

        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), d, lat);
            chk("clear_rd", d, 32'h0);
        end

        do_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        do_write(32'h10, 32'h0000_00AA, 4'b0001);
        do_read(32'h10, d, lat);
        chk("be_merge", d, 32'hDEAD_BEAA);
        chk("rd_latency", 32'(lat), 32'(LAT));

        do_write(32'h0, 32'd1, 4'hF);
        do_write(32'h4, 32'd2, 4'hF);
        do_write(32'h8, 32'd3, 4'hF);
        addr = 32'h0;
        rreq = 1'b1;
        tick();
        chk("b2b_v0", 32'(valid), 32'd0);
        addr = 32'h4;
        tick();
        chk("b2b_v1", 32'(valid), 32'd0);
        addr = 32'h8;
        tick();
        chk("b2b_v2", 32'(valid), 32'd1);
        chk("b2b_d2", rdata, 32'd1);
        rreq  = 1'b0;
        addr  = 32'h4;
        wdata = 32'h99;
        be    = 4'hF;
        wreq  = 1'b1;
        tick();
        wreq = 1'b0;
        chk("b2b_v3", 32'(valid), 32'd1);
        chk("b2b_d3", rdata, 32'd2);
        tick();
        chk("b2b_v4", 32'(valid), 32'd1);
        chk("b2b_d4", rdata, 32'd3);
        tick();
        chk("b2b_v5", 32'(valid), 32'd0);
        do_read(32'h4, d, lat);
        chk("late_wr", d, 32'h99);

        addr  = 32'h20;
        wdata = 32'h5A5A_5A5A;
        be    = 4'hF;
        wreq  = 1'b1;
        rreq  = 1'b1;
        tick();
        wreq = 1'b0;
        rreq = 1'b0;
        seen = valid;
        repeat (4) begin
            tick();
            seen = seen | valid;
        end
        chk("coll_novalid", 32'(seen), 32'd0);
        do_read(32'h20, d, lat);
        chk("coll_write", d, 32'h5A5A_5A5A);

        do_write(32'h44, 32'h1234_5678, 4'hF);
        do_read(32'h04, d, lat);
        chk("alias", d, 32'h1234_5678);
        do_write(32'h04, 32'hFFFF_FFFF, 4'h0);
        do_read(32'h04, d, lat);
        chk("be_zero", d, 32'h1234_5678);
        tick();
        tick();
        chk("hold_valid", 32'(valid), 32'd0);
        chk("hold_data", rdata, 32'h1234_5678);

        // reset while a read is in flight
        addr = 32'h10;
        rreq = 1'b1;
        tick();
        rreq  = 1'b0;
        reset = 1'b1;
        tick();
        chk("mr_ready", 32'(ready), 32'd0);
        chk("mr_valid", 32'(valid), 32'd0);
        chk("mr_rdata", rdata, 32'h0);
        reset = 1'b0;
        n     = 0;
        seen  = 1'b0;
        while (!ready && n < 100) begin
            tick();
            n++;
            seen = seen | valid;
        end
        chk("mr_clear_cycles", 32'(n), 32'd16);
        chk("mr_no_valid", 32'(seen), 32'd0);
        do_read(32'h10, d, lat);
        chk("mr_cleared", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
